// File: rtl/taus_pkg.sv
// Shared constants for the Tausworthe checker: component masks, shift amounts,
// default seeds and the checker state encoding.
package taus_pkg;

  localparam logic [31:0] MASK0 = 32'hFFFFFFFE;
  localparam logic [31:0] MASK1 = 32'hFFFFFFF8;
  localparam logic [31:0] MASK2 = 32'hFFFFFFF0;

  // Each component is ((s & mask) << C) ^ (((s << A) ^ s) >> B)
  localparam int unsigned S0_A = 13;
  localparam int unsigned S0_B = 19;
  localparam int unsigned S0_C = 12;
  localparam int unsigned S1_A = 2;
  localparam int unsigned S1_B = 25;
  localparam int unsigned S1_C = 4;
  localparam int unsigned S2_A = 3;
  localparam int unsigned S2_B = 11;
  localparam int unsigned S2_C = 17;

  localparam logic [31:0] DEF_SEED0 = 32'd2;
  localparam logic [31:0] DEF_SEED1 = 32'd7;
  localparam logic [31:0] DEF_SEED2 = 32'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACQ    = 3'd1,
    ST_SRCH   = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } chk_state_e;

endpackage

// File: rtl/taus_step.sv
// One combinational step of the three-component Tausworthe recurrence; word is
// the output value for the current (un-stepped) state.
module taus_step
  import taus_pkg::*;
(
  input  logic [31:0] s0,
  input  logic [31:0] s1,
  input  logic [31:0] s2,
  output logic [31:0] n0,
  output logic [31:0] n1,
  output logic [31:0] n2,
  output logic [31:0] word
);

  assign n0   = ((s0 & MASK0) << S0_C) ^ (((s0 << S0_A) ^ s0) >> S0_B);
  assign n1   = ((s1 & MASK1) << S1_C) ^ (((s1 << S1_A) ^ s1) >> S1_B);
  assign n2   = ((s2 & MASK2) << S2_C) ^ (((s2 << S2_A) ^ s2) >> S2_B);
  assign word = s0 ^ s1 ^ s2;

endmodule

// File: rtl/taus_checker.sv
// Receive-side Tausworthe stream checker: acquires alignment by searching a local
// copy of the sequence, then counts mismatching words. TAUS_CHK_BITERR_EN adds a bit-error counter.
module taus_checker
  import taus_pkg::*;
#(
  parameter logic [31:0] SEED0        = DEF_SEED0,
  parameter logic [31:0] SEED1        = DEF_SEED1,
  parameter logic [31:0] SEED2        = DEF_SEED2,
  parameter int          SEARCH_DEPTH = 1024,
  parameter int          LOSS_THRESH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sync,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        locked,
  output logic        search_fail,
  output logic        err_pulse,
  output logic [15:0] err_count,
  output logic [31:0] bit_err_count,
  output logic [2:0]  dbg_state
);

  // Handshake: a word transfers on a rising clk edge where din_valid & din_ready;
  // din_ready is a registered function of the state and never depends on din_valid.

  localparam int KW = $clog2(SEARCH_DEPTH);
  localparam int MW = $clog2(LOSS_THRESH + 1);
  localparam logic [KW-1:0] K_LAST    = KW'(SEARCH_DEPTH - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_THRESH);

  chk_state_e    state, state_next;
  logic [31:0]   s0, s1, s2;
  logic [31:0]   n0, n1, n2;
  logic [31:0]   exp_word;
  logic [31:0]   cap;
  logic [KW-1:0] k;
  logic [MW-1:0] miss_run;
  logic [MW-1:0] miss_inc;

  logic accept, mismatch;
  logic load_seeds, do_step, cap_load, k_clr, k_inc, cmp_en, miss_clr;

  taus_step u_step (
    .s0   (s0),
    .s1   (s1),
    .s2   (s2),
    .n0   (n0),
    .n1   (n1),
    .n2   (n2),
    .word (exp_word)
  );

  assign accept    = din_valid & din_ready;
  assign mismatch  = (din != exp_word);
  assign miss_inc  = miss_run + MW'(1);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_seeds = 1'b0;
    do_step    = 1'b0;
    cap_load   = 1'b0;
    k_clr      = 1'b0;
    k_inc      = 1'b0;
    cmp_en     = 1'b0;
    miss_clr   = 1'b0;
    if (sync) begin
      // sync overrides anything else happening this cycle, including an accepted word
      state_next = ST_ACQ;
      load_seeds = 1'b1;
      k_clr      = 1'b1;
      miss_clr   = 1'b1;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_ACQ: begin
          if (accept) begin
            cap_load   = 1'b1;
            load_seeds = 1'b1;
            k_clr      = 1'b1;
            state_next = ST_SRCH;
          end
        end
        ST_SRCH: begin
          if (exp_word == cap) begin
            do_step    = 1'b1;
            miss_clr   = 1'b1;
            state_next = ST_LOCKED;
          end else if (k == K_LAST) begin
            state_next = ST_FAIL;
          end else begin
            do_step = 1'b1;
            k_inc   = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (accept) begin
            cmp_en  = 1'b1;
            do_step = 1'b1;
            if (mismatch && (miss_inc == MISS_LAST)) begin
              miss_clr   = 1'b1;
              state_next = ST_ACQ;
            end
          end
        end
        ST_FAIL: ;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s0          <= SEED0;
      s1          <= SEED1;
      s2          <= SEED2;
      cap         <= '0;
      k           <= '0;
      miss_run    <= '0;
      err_count   <= '0;
      err_pulse   <= 1'b0;
      locked      <= 1'b0;
      search_fail <= 1'b0;
      din_ready   <= 1'b1;
    end else begin
      if (load_seeds) begin
        s0 <= SEED0;
        s1 <= SEED1;
        s2 <= SEED2;
      end else if (do_step) begin
        s0 <= n0;
        s1 <= n1;
        s2 <= n2;
      end
      if (cap_load) cap <= din;
      if (k_clr)      k <= '0;
      else if (k_inc) k <= k + KW'(1);
      if (miss_clr)    miss_run <= '0;
      else if (cmp_en) miss_run <= mismatch ? miss_inc : '0;
      if (sync) err_count <= '0;
      else if (cmp_en && mismatch && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
      err_pulse   <= cmp_en & mismatch;
      locked      <= (state_next == ST_LOCKED);
      search_fail <= (state_next == ST_FAIL);
      din_ready   <= (state_next != ST_SRCH);
    end
  end

`ifdef TAUS_CHK_BITERR_EN
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction

  logic [31:0] bit_err_q;
  logic [32:0] bit_sum;

  assign bit_sum       = {1'b0, bit_err_q} + {27'd0, popcount32(din ^ exp_word)};
  assign bit_err_count = bit_err_q;

  always_ff @(posedge clk) begin
    if (!reset)      bit_err_q <= '0;
    else if (sync)   bit_err_q <= '0;
    else if (cmp_en) bit_err_q <= bit_sum[32] ? 32'hFFFFFFFF : bit_sum[31:0];
  end
`else
  assign bit_err_count = 32'd0;
`endif

endmodule

// File: tb/tb_taus_checker.sv
// Directed bench for taus_checker: alignment, late start, corruption, loss of lock,
// search failure and reset mid-operation, against hand-computed sequence words.
module tb_taus_checker;
  import taus_pkg::*;

  logic        clk = 1'b0;
  logic        reset, sync, din_valid;
  logic [31:0] din;
  logic        din_ready, locked, search_fail, err_pulse;
  logic [15:0] err_count;
  logic [31:0] bit_err_count;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] bit_exp_one;

  always #5 clk = ~clk;

  taus_checker #(
    .SEARCH_DEPTH (16),
    .LOSS_THRESH  (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sync          (sync),
    .din           (din),
    .din_valid     (din_valid),
    .din_ready     (din_ready),
    .locked        (locked),
    .search_fail   (search_fail),
    .err_pulse     (err_pulse),
    .err_count     (err_count),
    .bit_err_count (bit_err_count),
    .dbg_state     (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag, input chk_state_e exp);
    chk(tag, 32'(dbg_state), 32'(exp));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] w);
    din       = w;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    din       = 32'd0;
  endtask

  task automatic do_sync();
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
  endtask

  initial begin
    // Generator words for indices 0..15 from seeds 2/7/5 (components 1 and 2 go to zero after one step)
    exp_q = '{32'h00000000, 32'h00002000, 32'h02000080, 32'h00080042,
              32'h80042000, 32'h42000080, 32'h00080842, 32'h80842020,
              32'h42020090, 32'h20090042, 32'h90042000, 32'h42000280,
              32'h0028084A, 32'h8084A024, 32'h4A024290, 32'h2429004A};
`ifdef TAUS_CHK_BITERR_EN
    bit_exp_one = 32'd1;
`else
    bit_exp_one = 32'd0;
`endif
    reset = 1'b0; sync = 1'b0; din_valid = 1'b0; din = 32'd0;
    repeat (2) tick();
    chk_state("rst_state", ST_IDLE);
    chk("rst_ready", 32'(din_ready), 32'd1);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_fail", 32'(search_fail), 32'd0);
    chk("rst_pulse", 32'(err_pulse), 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    chk("rst_biterr", bit_err_count, 32'd0);
    reset = 1'b1;
    tick();
    send(32'h12345678);
    chk_state("idle_discard", ST_IDLE);

    // Aligned stream
    do_sync();
    chk_state("t1_acq", ST_ACQ);
    chk("t1_acq_ready", 32'(din_ready), 32'd1);
    send(exp_q[0]);
    chk_state("t1_srch", ST_SRCH);
    chk("t1_srch_ready", 32'(din_ready), 32'd0);
    tick();
    chk("t1_locked", 32'(locked), 32'd1);
    for (int i = 1; i < 3; i++) begin
      send(exp_q[i]);
      chk("t1_no_pulse", 32'(err_pulse), 32'd0);
    end
    chk("t1_errcnt", 32'(err_count), 32'd0);

    // Single corruption at index 3
    send(exp_q[3] ^ 32'd1);
    chk("t2_pulse", 32'(err_pulse), 32'd1);
    chk("t2_errcnt", 32'(err_count), 32'd1);
    chk("t2_locked", 32'(locked), 32'd1);
    chk("t2_biterr", bit_err_count, bit_exp_one);
    tick();
    chk("t2_pulse_drop", 32'(err_pulse), 32'd0);
    send(exp_q[4]);
    chk("t2_next_ok", 32'(err_pulse), 32'd0);
    send(exp_q[5]);
    chk("t2_errcnt_hold", 32'(err_count), 32'd1);

    // Late start on index 2
    do_sync();
    chk("t3_errcnt_clr", 32'(err_count), 32'd0);
    chk("t3_biterr_clr", bit_err_count, 32'd0);
    chk("t3_locked_clr", 32'(locked), 32'd0);
    send(exp_q[2]);
    for (int i = 0; i < 3; i++) begin
      chk("t3_ready_low", 32'(din_ready), 32'd0);
      tick();
    end
    chk("t3_locked", 32'(locked), 32'd1);
    chk("t3_ready_high", 32'(din_ready), 32'd1);
    for (int i = 3; i < 8; i++) begin
      send(exp_q[i]);
      chk("t3_no_pulse", 32'(err_pulse), 32'd0);
    end
    chk("t3_errcnt", 32'(err_count), 32'd0);

    // Loss of lock after 8 consecutive wrong words (indices 1..8)
    do_sync();
    send(exp_q[0]);
    tick();
    chk("t4_locked", 32'(locked), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      send(32'hFFFFFFFF);
      chk("t4_pulse", 32'(err_pulse), 32'd1);
      if (i < 8) chk("t4_still_locked", 32'(locked), 32'd1);
    end
    chk("t4_unlocked", 32'(locked), 32'd0);
    chk("t4_errcnt", 32'(err_count), 32'd8);
    chk_state("t4_acq", ST_ACQ);
    chk("t4_ready", 32'(din_ready), 32'd1);
    tick();
    chk("t4_errcnt_held", 32'(err_count), 32'd8);
    chk("t4_pulse_drop", 32'(err_pulse), 32'd0);

    // Reset during SRCH
    send(exp_q[2]);
    tick();
    chk_state("t5_srch", ST_SRCH);
    reset = 1'b0;
    tick();
    chk_state("t5_idle", ST_IDLE);
    chk("t5_locked", 32'(locked), 32'd0);
    chk("t5_errcnt", 32'(err_count), 32'd0);
    chk("t5_ready", 32'(din_ready), 32'd1);
    reset = 1'b1;
    tick();

    // Reset during LOCKED
    do_sync();
    send(exp_q[0]);
    tick();
    chk_state("t6_locked_state", ST_LOCKED);
    send(32'hFFFFFFFF);
    chk("t6_errcnt_pre", 32'(err_count), 32'd1);
    reset = 1'b0;
    tick();
    chk_state("t6_idle", ST_IDLE);
    chk("t6_locked", 32'(locked), 32'd0);
    chk("t6_errcnt", 32'(err_count), 32'd0);
    chk("t6_pulse", 32'(err_pulse), 32'd0);
    chk("t6_ready", 32'(din_ready), 32'd1);
    reset = 1'b1;
    tick();

    // Search failure with SEARCH_DEPTH=16
    do_sync();
    send(32'hDEADBEEF);
    repeat (15) tick();
    chk("t7_not_yet", 32'(search_fail), 32'd0);
    chk_state("t7_srch", ST_SRCH);
    tick();
    chk("t7_fail", 32'(search_fail), 32'd1);
    chk_state("t7_fail_state", ST_FAIL);
    chk("t7_ready", 32'(din_ready), 32'd1);
    send(exp_q[0]);
    chk_state("t7_ignored", ST_FAIL);
    chk("t7_no_lock", 32'(locked), 32'd0);
    do_sync();
    chk("t7_fail_clr", 32'(search_fail), 32'd0);
    chk_state("t7_acq", ST_ACQ);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
